// File: rtl/single_macc_frac_interp.sv
// Fractional-rate (L/M) polyphase FIR interpolator built on a single multiply-accumulate.
// Latency: first output T+3 cycles after the accepted sample, then one output every T+3 cycles.
// Backpressure: none; a sample arriving while Busy_o is high is dropped and flagged on Overrun_o.
// Ports:
//   Clk_i, Rst_i                          clock, asynchronous active-high reset
//   CoeffAddr_i/CoeffData_i/CoeffWr_i     coefficient RAM write port (address = phase*T + tap)
//   Data_i/DataNd_i                       Q1.17 input sample and new-sample strobe
//   Data_o/DataValid_o                    Q1.17 output sample (held) and one-cycle valid pulse
//   Busy_o/Overrun_o                      computation in progress / dropped-sample pulse
module single_macc_frac_interp #(
  parameter int InterpolationK = 3,
  parameter int DecimationK    = 2,
  parameter int TapsPerPhase   = 4
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic [3:0]  CoeffAddr_i,
  input  logic [17:0] CoeffData_i,
  input  logic        CoeffWr_i,
  input  logic [17:0] Data_i,
  input  logic        DataNd_i,
  output logic [17:0] Data_o,
  output logic        DataValid_o,
  output logic        Busy_o,
  output logic        Overrun_o
);

  localparam int L  = InterpolationK;
  localparam int M  = DecimationK;
  localparam int T  = TapsPerPhase;
  // Phase arithmetic reaches up to 2L-1 before wrapping.
  localparam int PW = (L > 1) ? $clog2(2 * L) : 1;
  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam logic [PW-1:0] MP    = PW'(M);
  localparam logic [PW-1:0] LP    = PW'(L);
  localparam logic [TW-1:0] TLAST = TW'(T - 1);

  if (!(M >= 1 && M <= L && T >= 1 && L * T <= 16)) begin : g_param_check
    $error("single_macc_frac_interp: illegal parameters (need 1 <= M <= L, T >= 1, L*T <= 16)");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_DUMP} state_t;

  state_t             state_q;
  logic [TW-1:0]      tap_q;
  logic               flush_q;
  logic [PW-1:0]      phase_q;
  logic signed [17:0] dly_q [T];
  logic signed [17:0] rd_dly_q;
  logic signed [17:0] coeff_rd_q;
  logic               rd_vld_q;
  logic signed [35:0] prod_q;
  logic               prod_vld_q;
  logic signed [39:0] acc_q;
  logic signed [39:0] acc_d;
  logic signed [39:0] shifted;
  logic signed [17:0] sat_d;
  logic [17:0]        data_q;
  logic               valid_q;
  logic               busy_q;
  logic               ovr_q;
  logic [PW-1:0]      phase_nxt;
  logic [3:0]         rd_addr;
  logic signed [17:0] ram_q [16];

  assign rd_addr   = 4'(int'(phase_q) * T + int'(tap_q));
  assign phase_nxt = phase_q + MP;

  // Coefficient RAM: not reset. The registered read sees the pre-write contents
  // when it hits the address being written in the same cycle.
  always_ff @(posedge Clk_i) begin
    if (CoeffWr_i) begin
      ram_q[CoeffAddr_i] <= $signed(CoeffData_i);
    end
    coeff_rd_q <= ram_q[rd_addr];
  end

  // The accumulator absorbs each product two cycles after its MAC read.
  always_comb begin
    acc_d = acc_q;
    if (prod_vld_q) begin
      acc_d = acc_q + {{4{prod_q[35]}}, prod_q};
    end
    shifted = acc_d >>> 17;
    sat_d   = shifted[17:0];
    if (shifted > 40'sd131071) begin
      sat_d = 18'sd131071;
    end else if (shifted < -40'sd131072) begin
      sat_d = -18'sd131072;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q    <= S_IDLE;
      tap_q      <= '0;
      flush_q    <= 1'b0;
      phase_q    <= '0;
      for (int i = 0; i < T; i++) dly_q[i] <= '0;
      rd_dly_q   <= '0;
      rd_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      ovr_q      <= DataNd_i & busy_q;
      rd_vld_q   <= 1'b0;
      rd_dly_q   <= dly_q[tap_q];
      prod_q     <= 36'(rd_dly_q) * 36'(coeff_rd_q);
      prod_vld_q <= rd_vld_q;
      acc_q      <= acc_d;

      case (state_q)
        S_IDLE: begin
          if (DataNd_i) begin
            for (int i = 1; i < T; i++) dly_q[i] <= dly_q[i-1];
            dly_q[0] <= $signed(Data_i);
            busy_q   <= 1'b1;
            tap_q    <= '0;
            state_q  <= S_MAC;
          end
        end
        S_MAC: begin
          rd_vld_q <= 1'b1;
          if (tap_q == TLAST) begin
            flush_q <= 1'b0;
            state_q <= S_FLUSH;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        S_FLUSH: begin
          // Output is registered from the final sum so it appears during DUMP.
          if (flush_q) begin
            data_q  <= sat_d;
            valid_q <= 1'b1;
            state_q <= S_DUMP;
          end else begin
            flush_q <= 1'b1;
          end
        end
        S_DUMP: begin
          acc_q <= '0;
          tap_q <= '0;
          if (phase_nxt < LP) begin
            phase_q <= phase_nxt;
            state_q <= S_MAC;
          end else begin
            phase_q <= phase_nxt - LP;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = valid_q;
  assign Busy_o      = busy_q;
  assign Overrun_o   = ovr_q;

endmodule

// File: tb/tb_single_macc_frac_interp.sv
// Directed bench for single_macc_frac_interp with default parameters (L=3, M=2, T=4).
module tb_single_macc_frac_interp;

  logic        Clk_i = 1'b0;
  logic        Rst_i;
  logic [3:0]  CoeffAddr_i;
  logic [17:0] CoeffData_i;
  logic        CoeffWr_i;
  logic [17:0] Data_i;
  logic        DataNd_i;
  logic [17:0] Data_o;
  logic        DataValid_o;
  logic        Busy_o;
  logic        Overrun_o;

  single_macc_frac_interp dut (
    .Clk_i       (Clk_i),
    .Rst_i       (Rst_i),
    .CoeffAddr_i (CoeffAddr_i),
    .CoeffData_i (CoeffData_i),
    .CoeffWr_i   (CoeffWr_i),
    .Data_i      (Data_i),
    .DataNd_i    (DataNd_i),
    .Data_o      (Data_o),
    .DataValid_o (DataValid_o),
    .Busy_o      (Busy_o),
    .Overrun_o   (Overrun_o)
  );

  always #5 Clk_i = ~Clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int ovr_cyc = -1;
  logic signed [17:0] vq[$];
  int vc[$];

  always @(posedge Clk_i) cyc <= cyc + 1;

  // Output capture away from the active edge.
  always @(negedge Clk_i) begin
    if (DataValid_o === 1'b1) begin
      vq.push_back($signed(Data_o));
      vc.push_back(cyc);
    end
    if (Overrun_o === 1'b1) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge Clk_i);
      #1;
    end
  endtask

  task automatic clear_capture();
    vq.delete();
    vc.delete();
    ovr_cnt = 0;
    ovr_cyc = -1;
  endtask

  task automatic do_reset();
    Rst_i = 1'b1;
    tick(2);
    Rst_i = 1'b0;
    tick(1);
    clear_capture();
  endtask

  // mode 0: (a+1)*8192, mode 1: 32768, mode 2: 131071
  task automatic load_coeffs(input int mode);
    for (int a = 0; a < 16; a++) begin
      CoeffAddr_i = 4'(a);
      case (mode)
        0:       CoeffData_i = 18'((a + 1) * 8192);
        1:       CoeffData_i = 18'd32768;
        default: CoeffData_i = 18'd131071;
      endcase
      CoeffWr_i = 1'b1;
      tick(1);
    end
    CoeffWr_i = 1'b0;
  endtask

  task automatic send(input int s, output int n);
    Data_i   = 18'(s);
    DataNd_i = 1'b1;
    n        = cyc;
    tick(1);
    DataNd_i = 1'b0;
    Data_i   = '0;
  endtask

  task automatic test_reset();
    Rst_i = 1'b1;
    #2;
    checks++; if (Data_o !== 18'd0) begin errors++; $display("FAIL reset_data got %0d want 0", Data_o); end
    checks++; if (DataValid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", DataValid_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy_o); end
    checks++; if (Overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", Overrun_o); end
    @(posedge Clk_i);
    #1;
    Rst_i = 1'b0;
    tick(1);
  endtask

  task automatic test_impulse_latency();
    int exp_v[5] = '{4096, 36864, 24576, 12288, 45056};
    int n0, n1, n2;
    load_coeffs(0);
    do_reset();
    send(65536, n0);
    checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL busy_after_nd got %b want 1", Busy_o); end
    tick(13);
    checks++; if (Busy_o !== 1'b1) begin errors++; $display("FAIL busy_n14 got %b want 1", Busy_o); end
    tick(1);
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL busy_n15 got %b want 0", Busy_o); end
    tick(17);
    send(0, n1);
    tick(31);
    send(0, n2);
    tick(31);
    checks++; if (vq.size() != 5) begin errors++; $display("FAIL impulse_count got %0d want 5", vq.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= vq.size()) begin
        errors++; $display("FAIL impulse[%0d] got none want %0d", i, exp_v[i]);
      end else if (int'(vq[i]) !== exp_v[i]) begin
        errors++; $display("FAIL impulse[%0d] got %0d want %0d", i, vq[i], exp_v[i]);
      end
    end
    if (vc.size() >= 3) begin
      checks++; if (vc[0] != n0 + 7) begin errors++; $display("FAIL latency_first got cycle %0d want %0d", vc[0], n0 + 7); end
      checks++; if (vc[1] != n0 + 14) begin errors++; $display("FAIL latency_second got cycle %0d want %0d", vc[1], n0 + 14); end
      checks++; if (vc[2] != n1 + 7) begin errors++; $display("FAIL latency_third got cycle %0d want %0d", vc[2], n1 + 7); end
    end else begin
      checks++; errors++; $display("FAIL latency_capture got %0d valids want >= 3", vc.size());
    end
  endtask

  task automatic test_back_to_back();
    int exp_v[3] = '{4096, 36864, 24576};
    int n0, n1;
    do_reset();
    send(65536, n0);
    tick(14);
    send(0, n1);
    tick(30);
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL b2b_overrun got %0d want 0", ovr_cnt); end
    checks++; if (vq.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", vq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= vq.size()) begin
        errors++; $display("FAIL b2b[%0d] got none want %0d", i, exp_v[i]);
      end else if (int'(vq[i]) !== exp_v[i]) begin
        errors++; $display("FAIL b2b[%0d] got %0d want %0d", i, vq[i], exp_v[i]);
      end
    end
    if (vc.size() >= 3) begin
      checks++; if (vc[2] != n0 + 22) begin errors++; $display("FAIL b2b_latency got cycle %0d want %0d", vc[2], n0 + 22); end
    end
  endtask

  task automatic test_overrun();
    int exp_v[3] = '{4096, 36864, 24576};
    int n0, n1, n2;
    do_reset();
    send(65536, n0);
    tick(2);
    send(12345, n1);
    tick(28);
    send(0, n2);
    tick(31);
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL overrun_count got %0d want 1", ovr_cnt); end
    checks++; if (ovr_cyc != n0 + 4) begin errors++; $display("FAIL overrun_cycle got %0d want %0d", ovr_cyc, n0 + 4); end
    checks++; if (vq.size() != 3) begin errors++; $display("FAIL overrun_outputs got %0d want 3", vq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= vq.size()) begin
        errors++; $display("FAIL overrun_val[%0d] got none want %0d", i, exp_v[i]);
      end else if (int'(vq[i]) !== exp_v[i]) begin
        errors++; $display("FAIL overrun_val[%0d] got %0d want %0d", i, vq[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    int exp_v[5] = '{4096, 36864, 24576, 12288, 45056};
    int n0, n1;
    do_reset();
    send(65536, n0);
    tick(1);
    Rst_i = 1'b1;
    tick(1);
    Rst_i = 1'b0;
    tick(30);
    checks++; if (vq.size() != 0) begin errors++; $display("FAIL midreset_valids got %0d want 0", vq.size()); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", Busy_o); end
    clear_capture();
    send(65536, n1);
    tick(31);
    send(0, n1);
    tick(31);
    send(0, n1);
    tick(31);
    checks++; if (vq.size() != 5) begin errors++; $display("FAIL midreset_count got %0d want 5", vq.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= vq.size()) begin
        errors++; $display("FAIL midreset[%0d] got none want %0d", i, exp_v[i]);
      end else if (int'(vq[i]) !== exp_v[i]) begin
        errors++; $display("FAIL midreset[%0d] got %0d want %0d", i, vq[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_dc_gain();
    int n;
    load_coeffs(1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(65536, n);
      tick(15);
    end
    clear_capture();
    for (int k = 0; k < 4; k++) begin
      send(65536, n);
      tick(15);
    end
    checks++; if (vq.size() != 6) begin errors++; $display("FAIL dc_count got %0d want 6", vq.size()); end
    for (int i = 0; i < vq.size(); i++) begin
      checks++;
      if (int'(vq[i]) !== 65536) begin errors++; $display("FAIL dc[%0d] got %0d want 65536", i, vq[i]); end
    end
  endtask

  task automatic test_saturation();
    int n;
    load_coeffs(2);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(131071, n);
      tick(15);
    end
    clear_capture();
    send(131071, n);
    tick(15);
    checks++; if (vq.size() != 1) begin errors++; $display("FAIL sat_pos_count got %0d want 1", vq.size()); end
    checks++;
    if (vq.size() < 1 || int'(vq[0]) !== 131071) begin
      errors++; $display("FAIL sat_pos got %0d want 131071", (vq.size() > 0) ? int'(vq[0]) : 0);
    end
    for (int k = 0; k < 3; k++) begin
      send(-131072, n);
      tick(15);
    end
    clear_capture();
    send(-131072, n);
    tick(15);
    checks++; if (vq.size() != 1) begin errors++; $display("FAIL sat_neg_count got %0d want 1", vq.size()); end
    checks++;
    if (vq.size() < 1 || int'(vq[0]) !== -131072) begin
      errors++; $display("FAIL sat_neg got %0d want -131072", (vq.size() > 0) ? int'(vq[0]) : 0);
    end
  endtask

  initial begin
    Rst_i       = 1'b0;
    CoeffAddr_i = '0;
    CoeffData_i = '0;
    CoeffWr_i   = 1'b0;
    Data_i      = '0;
    DataNd_i    = 1'b0;
    @(posedge Clk_i);
    #1;
    test_reset();
    test_impulse_latency();
    test_back_to_back();
    test_overrun();
    test_reset_mid_mac();
    test_dc_gain();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
